// File: rtl/gcn_readout_pkg.sv
// Shared types for the GCN readout stage.
//   argmax_state_t : sequencer states of arg_max_readout
package gcn_readout_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      WRITE,
      DONE
   } argmax_state_t;

endpackage

// File: rtl/argmax_row.sv
// Combinational argmax over one result row.
//   row : WEIGHT_COLS scores; column c occupies bits [c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]
//   idx : index of the largest score; ties go to the lowest column
module argmax_row
   import gcn_readout_pkg::*;
#(
   parameter int unsigned WEIGHT_COLS       = 3,
   parameter int unsigned DOT_PROD_WIDTH    = 16,
   parameter int unsigned SIGNED_CMP        = 1,
   parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
) (
   input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] row,
   output logic [MAX_ADDRESS_WIDTH-1:0]          idx
);

   logic [DOT_PROD_WIDTH-1:0] best_val;
   logic [DOT_PROD_WIDTH-1:0] cur_val;
   logic                      greater;

   // Linear scan; only a strictly greater score replaces the running best, so the
   // earliest column wins every tie and an all-equal row yields 0.
   always_comb begin
      best_val = row[DOT_PROD_WIDTH-1:0];
      idx      = '0;
      cur_val  = '0;
      greater  = 1'b0;
      for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
         cur_val = row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
         if (SIGNED_CMP != 0) begin
            greater = $signed(cur_val) > $signed(best_val);
         end else begin
            greater = cur_val > best_val;
         end
         if (greater) begin
            best_val = cur_val;
            idx      = MAX_ADDRESS_WIDTH'(c);
         end
      end
   end

endmodule

// File: rtl/arg_max_readout.sv
// Readout stage: scans NUM_OF_NODES result rows, writes each row's argmax class index.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : level request, sampled only in IDLE
//   read_en/read_addr     : row read strobe and row address (data returns next cycle)
//   read_data             : row of WEIGHT_COLS scores
//   write_en/write_addr   : result write strobe and node index
//   write_data            : argmax class index
//   busy                  : pass in progress (READ/WAIT/WRITE)
//   done                  : pass finished; held while start stays high
module arg_max_readout
   import gcn_readout_pkg::*;
#(
   parameter int unsigned NUM_OF_NODES      = 6,
   parameter int unsigned WEIGHT_COLS       = 3,
   parameter int unsigned DOT_PROD_WIDTH    = 16,
   parameter int unsigned SIGNED_CMP        = 1,
   parameter int unsigned NODE_ADDR_WIDTH   = $clog2(NUM_OF_NODES),
   parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   output logic                                  read_en,
   output logic [NODE_ADDR_WIDTH-1:0]            read_addr,
   input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] read_data,
   output logic                                  write_en,
   output logic [NODE_ADDR_WIDTH-1:0]            write_addr,
   output logic [MAX_ADDRESS_WIDTH-1:0]          write_data,
   output logic                                  busy,
   output logic                                  done
);

   localparam logic [NODE_ADDR_WIDTH-1:0] LAST_NODE = NODE_ADDR_WIDTH'(NUM_OF_NODES - 1);

   argmax_state_t                state;
   logic [NODE_ADDR_WIDTH-1:0]   node_cnt;
   logic [MAX_ADDRESS_WIDTH-1:0] row_idx;

   argmax_row #(
      .WEIGHT_COLS      (WEIGHT_COLS),
      .DOT_PROD_WIDTH   (DOT_PROD_WIDTH),
      .SIGNED_CMP       (SIGNED_CMP),
      .MAX_ADDRESS_WIDTH(MAX_ADDRESS_WIDTH)
   ) u_argmax_row (
      .row(read_data),
      .idx(row_idx)
   );

   // Outputs are registered alongside the state: each branch loads the values that belong
   // to the state being entered, so they stay a pure function of the current state.
   // write_data doubles as the result register: loaded in WAIT, presented in WRITE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         node_cnt   <= '0;
         read_en    <= 1'b0;
         read_addr  <= '0;
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         read_en    <= 1'b0;
         read_addr  <= '0;
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= READ;
                  node_cnt <= '0;
                  read_en  <= 1'b0 | 1'b1;
                  busy     <= 1'b1;
               end
            end
            READ: begin
               state <= WAIT;
               busy  <= 1'b1;
            end
            WAIT: begin
               state      <= WRITE;
               write_en   <= 1'b1;
               write_addr <= node_cnt;
               write_data <= row_idx;
               busy       <= 1'b1;
            end
            WRITE: begin
               if (node_cnt == LAST_NODE) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= READ;
                  node_cnt  <= node_cnt + 1'b1;
                  read_en   <= 1'b1;
                  read_addr <= node_cnt + 1'b1;
                  busy      <= 1'b1;
               end
            end
            DONE: begin
               // Leaving DONE needs start to drop, so a held start never retriggers a pass.
               if (start) begin
                  done <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arg_max_readout.sv
module tb_arg_max_readout;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- instance A: default parameters ----------------
   logic        a_start = 1'b0;
   logic        a_read_en, a_write_en, a_busy, a_done;
   logic [2:0]  a_read_addr, a_write_addr;
   logic [1:0]  a_write_data;
   logic [47:0] a_read_data = '0;
   logic [47:0] mem_a [6];

   arg_max_readout u_a (
      .clk(clk), .reset(reset), .start(a_start),
      .read_en(a_read_en), .read_addr(a_read_addr), .read_data(a_read_data),
      .write_en(a_write_en), .write_addr(a_write_addr), .write_data(a_write_data),
      .busy(a_busy), .done(a_done)
   );

   always @(posedge clk) if (a_read_en) a_read_data <= mem_a[a_read_addr];

   int a_s = 0;
   int wa_addr[$];
   int wa_data[$];
   int wa_cyc[$];
   always @(posedge clk) begin
      if (a_write_en) begin
         wa_addr.push_back(int'(a_write_addr));
         wa_data.push_back(int'(a_write_data));
         wa_cyc.push_back(edge_cnt - a_s);
      end
   end

   typedef struct {
      int s0;
      int s1;
      int s2;
      int exp;
   } vec_t;
   vec_t tbl[6];

   // ---------------- instances U/S: unsigned vs signed on the same row ----------------
   logic        u_start = 1'b0, s_start = 1'b0;
   logic        u_read_en, u_write_en, u_busy, u_done;
   logic        s_read_en, s_write_en, s_busy, s_done;
   logic        u_read_addr, u_write_addr, s_read_addr, s_write_addr;
   logic [1:0]  u_write_data, s_write_data;
   logic [47:0] us_row = 48'h0000_0001_FFFF;

   arg_max_readout #(.NUM_OF_NODES(2), .SIGNED_CMP(0)) u_u (
      .clk(clk), .reset(reset), .start(u_start),
      .read_en(u_read_en), .read_addr(u_read_addr), .read_data(us_row),
      .write_en(u_write_en), .write_addr(u_write_addr), .write_data(u_write_data),
      .busy(u_busy), .done(u_done)
   );
   arg_max_readout #(.NUM_OF_NODES(2), .SIGNED_CMP(1)) u_s (
      .clk(clk), .reset(reset), .start(s_start),
      .read_en(s_read_en), .read_addr(s_read_addr), .read_data(us_row),
      .write_en(s_write_en), .write_addr(s_write_addr), .write_data(s_write_data),
      .busy(s_busy), .done(s_done)
   );

   int u_cnt = 0, s_cnt = 0, u_last = -1, s_last = -1;
   always @(posedge clk) begin
      if (u_write_en) begin
         u_cnt  <= u_cnt + 1;
         u_last <= int'(u_write_data);
      end
      if (s_write_en) begin
         s_cnt  <= s_cnt + 1;
         s_last <= int'(s_write_data);
      end
   end

   // ---------------- instance D: 10 nodes x 7 classes ----------------
   logic         d_start = 1'b0;
   logic         d_read_en, d_write_en, d_busy, d_done;
   logic [3:0]   d_read_addr, d_write_addr;
   logic [2:0]   d_write_data;
   logic [111:0] d_read_data = '0;
   logic [111:0] mem_d [10];
   int           exp_d [10];

   arg_max_readout #(.NUM_OF_NODES(10), .WEIGHT_COLS(7)) u_d (
      .clk(clk), .reset(reset), .start(d_start),
      .read_en(d_read_en), .read_addr(d_read_addr), .read_data(d_read_data),
      .write_en(d_write_en), .write_addr(d_write_addr), .write_data(d_write_data),
      .busy(d_busy), .done(d_done)
   );

   always @(posedge clk) if (d_read_en) d_read_data <= mem_d[d_read_addr];

   int d_s = 0;
   int wd_addr[$];
   int wd_data[$];
   int wd_cyc[$];
   always @(posedge clk) begin
      if (d_write_en) begin
         wd_addr.push_back(int'(d_write_addr));
         wd_data.push_back(int'(d_write_data));
         wd_cyc.push_back(edge_cnt - d_s);
      end
   end

   // One full pass on instance A, called at a negedge; start stays high through the pass,
   // then for 'hold' extra cycles in DONE, then drops.
   task automatic run_pass_a(input int hold);
      int   base, j, strobe_bad, held_bad;
      logic seen;
      base = wa_addr.size();
      a_s = edge_cnt;
      a_start = 1'b1;
      j = 0;
      seen = 1'b0;
      strobe_bad = 0;
      held_bad = 0;
      while (!seen && j < 100) begin
         @(negedge clk);
         j++;
         if (j == 1) begin
            chk("first_read_en", int'(a_read_en), 1);
            chk("first_read_addr", int'(a_read_addr), 0);
         end
         if (!a_write_en && (a_write_addr != 0 || a_write_data != 0)) strobe_bad++;
         if (!a_read_en && a_read_addr != 0) strobe_bad++;
         if (a_done) seen = 1'b1;
      end
      chk("done_cycle", j, 19);
      chk("addr_hold_zero", strobe_bad, 0);
      chk("write_count", wa_addr.size() - base, 6);
      for (int i = 0; i < 6; i++) begin
         if (base + i < wa_addr.size()) begin
            chk("write_addr", wa_addr[base+i], i);
            chk("write_data", wa_data[base+i], tbl[i].exp);
            chk("write_cycle", wa_cyc[base+i], 3*i + 3);
         end
      end
      repeat (hold) begin
         @(negedge clk);
         if (!a_done || a_busy) held_bad++;
      end
      chk("done_held", held_bad, 0);
      chk("no_restart", wa_addr.size() - base, 6);
      a_start = 1'b0;
      @(negedge clk);
      chk("done_cleared", int'(a_done), 0);
      chk("idle_not_busy", int'(a_busy), 0);
   endtask

   initial begin
      int base, j, idle_bad, hits;
      logic [15:0] v;

      tbl[0] = '{s0: 1,  s1: 5,  s2: 2,  exp: 1};
      tbl[1] = '{s0: 9,  s1: 3,  s2: 3,  exp: 0};
      tbl[2] = '{s0: 0,  s1: 0,  s2: 7,  exp: 2};
      tbl[3] = '{s0: 4,  s1: 4,  s2: 1,  exp: 0};
      tbl[4] = '{s0: -2, s1: -1, s2: -3, exp: 1};
      tbl[5] = '{s0: 6,  s1: 6,  s2: 6,  exp: 0};
      for (int i = 0; i < 6; i++) begin
         mem_a[i] = {16'(tbl[i].s2), 16'(tbl[i].s1), 16'(tbl[i].s0)};
      end

      // Node n peaks in column n%7; node 9 also ties that peak in column 5.
      for (int n = 0; n < 10; n++) begin
         exp_d[n] = n % 7;
         for (int c = 0; c < 7; c++) begin
            v = (c == n % 7 || (n == 9 && c == 5)) ? 16'(100 + n) : 16'(-50 + c);
            mem_d[n][c*16 +: 16] = v;
         end
      end

      // Reset and idle with start low.
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_quiet", int'({a_read_en, a_write_en, a_busy, a_done}), 0);
      end

      // Signed pass over the table, then a pass with start held in DONE, repeated.
      run_pass_a(0);
      run_pass_a(10);
      run_pass_a(0);

      // Asynchronous reset in WAIT of node 2 (cycle 8).
      base = wa_addr.size();
      a_s = edge_cnt;
      a_start = 1'b1;
      repeat (8) @(negedge clk);
      chk("pre_reset_busy", int'(a_busy), 1);
      #2;
      reset = 1'b1;
      a_start = 1'b0;
      #1;
      chk("reset_outputs_zero",
          int'({a_read_en, a_write_en, a_busy, a_done, a_read_addr, a_write_addr, a_write_data}), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("aborted_write_count", wa_addr.size() - base, 2);
      hits = 0;
      for (int i = base; i < wa_addr.size(); i++) if (wa_addr[i] == 2) hits++;
      chk("no_write_addr2", hits, 0);
      run_pass_a(0);

      // Unsigned vs signed on {FFFF, 0001, 0000}.
      u_start = 1'b1;
      s_start = 1'b1;
      j = 0;
      while (!(u_done && s_done) && j < 40) begin
         @(negedge clk);
         j++;
      end
      chk("us_done_cycle", j, 7);
      u_start = 1'b0;
      s_start = 1'b0;
      @(negedge clk);
      chk("unsigned_count", u_cnt, 2);
      chk("signed_count", s_cnt, 2);
      chk("unsigned_idx", u_last, 0);
      chk("signed_idx", s_last, 1);

      // 10 x 7 instance, with start pulses while busy.
      d_s = edge_cnt;
      d_start = 1'b1;
      j = 0;
      while (!d_done && j < 100) begin
         @(negedge clk);
         j++;
         if (j == 1 || j == 11 || j == 14) d_start = 1'b0;
         if (j == 10 || j == 13) d_start = 1'b1;
      end
      chk("d_done_cycle", j, 31);
      chk("d_write_count", wd_addr.size(), 10);
      for (int i = 0; i < 10; i++) begin
         if (i < wd_addr.size()) begin
            chk("d_write_addr", wd_addr[i], i);
            chk("d_write_data", wd_data[i], exp_d[i]);
            chk("d_write_cycle", wd_cyc[i], 3*i + 3);
         end
      end
      repeat (8) @(negedge clk);
      chk("d_idle_after", int'({d_busy, d_done}), 0);
      chk("d_no_extra_writes", wd_addr.size(), 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
